// File: rtl/zoran_nios_recv_data.sv
// Receive-side data port for the Nios: a valid/ready word stream is buffered in a
// FIFO that software drains through a four-register Avalon-MM slave with a level irq.
module zoran_nios_recv_data #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_port,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              read_n,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [1:0] A_DATA    = 2'd0;
   localparam logic [1:0] A_STATUS  = 2'd1;
   localparam logic [1:0] A_IRQMASK = 2'd2;
   localparam logic [1:0] A_CONTROL = 2'd3;

   typedef struct packed {
      logic push;
      logic pop;
      logic flush;
      logic ovr_set;
      logic ovr_clr;
      logic mask_wr;
   } ev_t;

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [PTR_W-1:0]             rd_ptr, wr_ptr;
   logic [CNT_W-1:0]             count;
   logic                         irq_en, overrun;
   logic                         rd_sel, wr_sel, empty, full;
   ev_t                          ev;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign in_ready = !full;
   assign irq      = irq_en && !empty;

   always_comb begin
      rd_sel     = chipselect && !read_n;
      wr_sel     = chipselect && !write_n;
      ev.push    = in_valid && in_ready;
      ev.pop     = rd_sel && (address == A_DATA) && !empty;
      // A DATA read with nothing buffered is a software underrun.
      ev.ovr_set = rd_sel && (address == A_DATA) && empty;
      ev.flush   = wr_sel && (address == A_CONTROL) && writedata[0];
      ev.ovr_clr = wr_sel && (address == A_CONTROL) && writedata[1];
      ev.mask_wr = wr_sel && (address == A_IRQMASK);
   end

   always_comb begin
      readdata = '0;
      if (rd_sel) begin
         case (address)
            A_DATA:    readdata = empty ? 32'd0 : 32'(mem[rd_ptr]);
            A_STATUS:  readdata = {16'd0, 8'(count), 5'd0, overrun, full, !empty};
            A_IRQMASK: readdata = {31'd0, irq_en};
            default:   readdata = '0;
         endcase
      end
   end

   // Storage carries no reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (ev.push) mem[wr_ptr] <= in_port;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         irq_en  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (ev.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (ev.push) wr_ptr <= wr_ptr + 1'b1;
            if (ev.pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(ev.push) - CNT_W'(ev.pop);
         end
         if (ev.ovr_set)      overrun <= 1'b1;
         else if (ev.ovr_clr) overrun <= 1'b0;
         if (ev.mask_wr) irq_en <= writedata[0];
      end
   end

   logic unused_wdata;
   assign unused_wdata = &{1'b0, writedata[31:2]};

   a_count_bound: assert property (@(posedge clk) count <= FULL_CNT);
   a_no_push_full: assert property (@(posedge clk) disable iff (reset) full |-> !ev.push);
endmodule
